// File: rtl/dsp_post_pkg.sv
// Shared types and constants for the FFT post-processing chain behind the CORDIC stage.
// peak_t fields are sized for the widest supported block: N_BINS <= 2^16 and WIDTH <= 64.
package dsp_post_pkg;

  localparam logic [15:0] CORDIC_GAIN_Q16 = 16'd39797;  // round(0.6072529350 * 2^16)
  localparam int          PHASE_W         = 32;
  localparam int          PEAK_BIN_W      = 16;
  localparam int          PEAK_MAG_W      = 64;

  typedef struct packed {
    logic [PEAK_BIN_W-1:0] bin;
    logic [PEAK_MAG_W-1:0] mag;
    logic [PHASE_W-1:0]    phase;
  } peak_t;

endpackage

// File: rtl/cordic_gain_comp.sv
// Removes the CORDIC gain: o_mag = (i_mag * CORDIC_GAIN_Q16) >> 16. The result is truncated.
// One registered stage, with valid and side-band passed through. There is no backpressure.
// The result holds between valids. PEAK_THRESH_EN adds a registered (o_mag >= i_thresh) flag.
module cordic_gain_comp
  import dsp_post_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIDE_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [WIDTH-1:0]  i_mag,
  input  logic [SIDE_W-1:0] i_side,
`ifdef PEAK_THRESH_EN
  input  logic [WIDTH-1:0]  i_thresh,
  output logic              o_det,
`endif
  output logic              o_vld,
  output logic [WIDTH-1:0]  o_mag,
  output logic [SIDE_W-1:0] o_side
);

  localparam int PW = WIDTH + 16;

  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] comp;
  logic             unused_frac;

  assign prod        = PW'(i_mag) * PW'(CORDIC_GAIN_Q16);
  assign comp        = prod[PW-1:16];
  assign unused_frac = ^prod[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld  <= 1'b0;
      o_mag  <= '0;
      o_side <= '0;
`ifdef PEAK_THRESH_EN
      o_det  <= 1'b0;
`endif
    end else begin
      o_vld <= i_vld;
      if (i_vld) begin
        o_mag  <= comp;
        o_side <= i_side;
`ifdef PEAK_THRESH_EN
        o_det  <= (comp >= i_thresh);
`endif
      end
    end
  end

endmodule

// File: rtl/spectrum_peak_detector.sv
// Finds the largest-magnitude bin in [BIN_LO, BIN_HI] of each frame. It emits bin, gain-compensated magnitude and phase.
// o_vld pulses two cycles after the last bin. There is no backpressure. PEAK_THRESH_EN adds i_thresh/o_det.
module spectrum_peak_detector
  import dsp_post_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int N_BINS = 1024,
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 511
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_vld,
  input  logic                      i_sof,
  input  logic [WIDTH-1:0]          i_mag,
  input  logic [PHASE_W-1:0]        i_phase,
`ifdef PEAK_THRESH_EN
  input  logic [WIDTH-1:0]          i_thresh,
  output logic                      o_det,
`endif
  output logic                      o_vld,
  output logic [$clog2(N_BINS)-1:0] o_bin,
  output logic [WIDTH-1:0]          o_mag,
  output logic [PHASE_W-1:0]        o_phase
);

  localparam int               BIN_W  = $clog2(N_BINS);
  localparam int               SIDE_W = BIN_W + PHASE_W;
  localparam logic [BIN_W-1:0] LO_B   = BIN_W'(BIN_LO);
  localparam logic [BIN_W-1:0] HI_B   = BIN_W'(BIN_HI);
  localparam logic [BIN_W-1:0] LAST_B = BIN_W'(N_BINS - 1);

  logic [BIN_W-1:0]   bin_cnt, cur_bin;
  logic [WIDTH-1:0]   mag_clamp;
  logic               in_win, found_eff, take, last;
  logic [WIDTH-1:0]   best_mag, nxt_mag;
  logic [BIN_W-1:0]   best_bin, nxt_bin;
  logic [PHASE_W-1:0] best_phase, nxt_phase;
  logic               found;
  peak_t              lat;
  logic               lat_vld;
  logic [SIDE_W-1:0]  out_side;
  logic               unused_lat;
`ifdef PEAK_THRESH_EN
  logic [WIDTH-1:0]   lat_thresh;
`endif

  // A start-of-frame sample is bin 0 and starts a fresh search whatever came before.
  assign cur_bin   = i_sof ? '0 : bin_cnt;
  assign mag_clamp = i_mag[WIDTH-1] ? '0 : i_mag;
  assign in_win    = (cur_bin >= LO_B) && (cur_bin <= HI_B);
  assign found_eff = found && !i_sof;
  assign take      = i_vld && in_win && (!found_eff || (mag_clamp > best_mag));
  assign last      = i_vld && (cur_bin == LAST_B);

  assign nxt_mag   = take ? mag_clamp : best_mag;
  assign nxt_bin   = take ? cur_bin   : best_bin;
  assign nxt_phase = take ? i_phase   : best_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt    <= '0;
      best_mag   <= '0;
      best_bin   <= LO_B;
      best_phase <= '0;
      found      <= 1'b0;
      lat        <= '0;
      lat_vld    <= 1'b0;
`ifdef PEAK_THRESH_EN
      lat_thresh <= '0;
`endif
    end else begin
      lat_vld <= last;
      if (i_vld) begin
        bin_cnt <= cur_bin + BIN_W'(1);
        if (last) begin
          lat.bin    <= PEAK_BIN_W'(nxt_bin);
          lat.mag    <= PEAK_MAG_W'(nxt_mag);
          lat.phase  <= nxt_phase;
`ifdef PEAK_THRESH_EN
          lat_thresh <= i_thresh;
`endif
          best_mag   <= '0;
          best_bin   <= LO_B;
          best_phase <= '0;
          found      <= 1'b0;
        end else if (take) begin
          best_mag   <= mag_clamp;
          best_bin   <= cur_bin;
          best_phase <= i_phase;
          found      <= 1'b1;
        end else if (i_sof) begin
          best_mag   <= '0;
          best_bin   <= LO_B;
          best_phase <= '0;
          found      <= 1'b0;
        end
      end
    end
  end

  assign unused_lat = ^lat;

  cordic_gain_comp #(
    .WIDTH  (WIDTH),
    .SIDE_W (SIDE_W)
  ) u_gain (
    .clk      (clk),
    .rst      (rst),
    .i_vld    (lat_vld),
    .i_mag    (WIDTH'(lat.mag)),
    .i_side   ({BIN_W'(lat.bin), lat.phase}),
`ifdef PEAK_THRESH_EN
    .i_thresh (lat_thresh),
    .o_det    (o_det),
`endif
    .o_vld    (o_vld),
    .o_mag    (o_mag),
    .o_side   (out_side)
  );

  assign o_bin   = out_side[SIDE_W-1:PHASE_W];
  assign o_phase = out_side[PHASE_W-1:0];

endmodule

// File: tb/tb_spectrum_peak_detector.sv
// Directed bench for spectrum_peak_detector with an 8-bin frame and a search window of bins 1..6.
module tb_spectrum_peak_detector;

  localparam int WIDTH  = 32;
  localparam int N_BINS = 8;
  localparam int BIN_LO = 1;
  localparam int BIN_HI = 6;
  localparam int BIN_W  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_vld = 1'b0;
  logic             i_sof = 1'b0;
  logic [WIDTH-1:0] i_mag = '0;
  logic [31:0]      i_phase = '0;
  logic             o_vld;
  logic [BIN_W-1:0] o_bin;
  logic [WIDTH-1:0] o_mag;
  logic [31:0]      o_phase;
`ifdef PEAK_THRESH_EN
  logic [WIDTH-1:0] i_thresh = '0;
  logic             o_det;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_edge = 0;

  logic [WIDTH-1:0] fm [N_BINS];
  logic [31:0]      fp [N_BINS];

  logic [63:0] q_bin[$];
  logic [63:0] q_mag[$];
  logic [63:0] q_phase[$];
  int          q_cyc[$];
  logic        q_det[$];

  spectrum_peak_detector #(
    .WIDTH  (WIDTH),
    .N_BINS (N_BINS),
    .BIN_LO (BIN_LO),
    .BIN_HI (BIN_HI)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_vld    (i_vld),
    .i_sof    (i_sof),
    .i_mag    (i_mag),
    .i_phase  (i_phase),
`ifdef PEAK_THRESH_EN
    .i_thresh (i_thresh),
    .o_det    (o_det),
`endif
    .o_vld    (o_vld),
    .o_bin    (o_bin),
    .o_mag    (o_mag),
    .o_phase  (o_phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_vld) begin
      q_bin.push_back(64'(o_bin));
      q_mag.push_back(64'(o_mag));
      q_phase.push_back(64'(o_phase));
      q_cyc.push_back(cyc);
`ifdef PEAK_THRESH_EN
      q_det.push_back(o_det);
`else
      q_det.push_back(1'b0);
`endif
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_q();
    q_bin.delete(); q_mag.delete(); q_phase.delete(); q_cyc.delete(); q_det.delete();
  endtask

  task automatic drive_bin(input logic sof, input logic [WIDTH-1:0] mag, input logic [31:0] ph);
    i_vld = 1'b1; i_sof = sof; i_mag = mag; i_phase = ph;
    @(posedge clk); #1;
    last_edge = cyc;
    i_vld = 1'b0; i_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_frame(input int gap);
    for (int b = 0; b < N_BINS; b++) begin
      drive_bin(b == 0, fm[b], fp[b]);
      if (b != N_BINS - 1) idle(gap);
    end
  endtask

  task automatic set_flat(input logic [WIDTH-1:0] v);
    for (int b = 0; b < N_BINS; b++) begin fm[b] = v; fp[b] = 32'(b) * 32'h0101_0101; end
  endtask

  task automatic set_basic();
    set_flat(32'd10);
    fm[3] = 32'd1000; fp[3] = 32'h1234_5678;
  endtask

  // The bench counts clock edges: o_vld is first seen one edge after the edge that registers stage 1.
  task automatic expect_one(input string tag, input int bin, input int mag);
    check({tag, "_count"}, 64'(q_bin.size()), 64'd1);
    if (q_bin.size() >= 1) begin
      check({tag, "_bin"}, q_bin[0], 64'(bin));
      check({tag, "_mag"}, q_mag[0], 64'(mag));
    end
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    idle(1);
    check("rst_o_vld", 64'(o_vld), 64'd0);
    check("rst_o_bin", 64'(o_bin), 64'd0);
    check("rst_o_mag", 64'(o_mag), 64'd0);
    check("rst_o_phase", 64'(o_phase), 64'd0);

    // Basic peak
    clear_q(); set_basic();
`ifdef PEAK_THRESH_EN
    i_thresh = 32'd607;
`endif
    run_frame(0); idle(4);
    expect_one("basic", 3, 607);
    if (q_bin.size() >= 1) begin
      check("basic_phase", q_phase[0], 64'h1234_5678);
      check("basic_latency", 64'(q_cyc[0] - last_edge), 64'd1);
`ifdef PEAK_THRESH_EN
      check("det_at_607", 64'(q_det[0]), 64'd1);
`endif
    end
    check("hold_mag", 64'(o_mag), 64'd607);
    check("hold_vld", 64'(o_vld), 64'd0);

`ifdef PEAK_THRESH_EN
    clear_q(); i_thresh = 32'd608;
    run_frame(0); idle(4);
    if (q_det.size() >= 1) check("det_at_608", 64'(q_det[0]), 64'd0);
    else check("det_at_608_count", 64'(q_det.size()), 64'd1);
`endif

    // Tie: earliest bin wins
    clear_q(); set_flat(32'd0);
    fm[2] = 32'd500; fm[5] = 32'd500;
    run_frame(0); idle(4);
    expect_one("tie", 2, 303);

    // Window exclusion, negative input clamped
    clear_q(); set_flat(32'd0);
    fm[0] = 32'd30000; fm[7] = 32'd30000; fm[4] = 32'd10; fm[5] = 32'hFFFF_FFFB;
    run_frame(0); idle(4);
    expect_one("window", 4, 6);

    // Gapped input, valid every 3rd cycle
    clear_q(); set_basic();
    run_frame(2); idle(4);
    expect_one("gapped", 3, 607);
    if (q_bin.size() >= 1) begin
      check("gapped_phase", q_phase[0], 64'h1234_5678);
      check("gapped_latency", 64'(q_cyc[0] - last_edge), 64'd1);
    end

    // Reset after bin 4, then a clean frame
    clear_q(); set_flat(32'd0); fm[2] = 32'd2000;
    for (int b = 0; b < 5; b++) drive_bin(b == 0, fm[b], fp[b]);
    rst = 1'b1; idle(1); rst = 1'b0;
    idle(4);
    check("rst_mid_no_out", 64'(q_bin.size()), 64'd0);
    set_basic();
    run_frame(0); idle(4);
    expect_one("after_rst", 3, 607);

    // Start of frame reasserted at old bin 5
    clear_q(); set_flat(32'd0); fm[2] = 32'd2000;
    for (int b = 0; b < 5; b++) drive_bin(b == 0, fm[b], fp[b]);
    set_basic();
    run_frame(0); idle(6);
    expect_one("resync", 3, 607);

    // Back-to-back frames, second peak on the upper window edge
    clear_q(); set_basic();
    run_frame(0);
    set_flat(32'd10); fm[6] = 32'd2000; fp[6] = 32'hCAFE_0006;
    run_frame(0); idle(4);
    check("b2b_count", 64'(q_bin.size()), 64'd2);
    if (q_bin.size() >= 2) begin
      check("b2b_first_bin", q_bin[0], 64'd3);
      check("b2b_second_bin", q_bin[1], 64'd6);
      check("b2b_second_mag", q_mag[1], 64'd1214);
      check("b2b_second_phase", q_phase[1], 64'hCAFE_0006);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spectrum_peak_detector.md
Name: spectrum_peak_detector

Overview:
Sits directly downstream of the rectangular-to-polar CORDIC stage in the FFT post-processing chain. Consumes one magnitude/phase pair per FFT bin and tracks the largest-magnitude bin inside a configurable search window. Once per frame it emits the peak bin index, the CORDIC-gain-compensated magnitude and the phase.

Parameters:
WIDTH, 32, bit width of the magnitude input and output (signed input, same as the CORDIC output).
N_BINS, 1024, bins per frame; power of two, >= 4.
BIN_LO, 1, first bin index included in the search (inclusive).
BIN_HI, 511, last bin index included in the search (inclusive); requires BIN_LO <= BIN_HI < N_BINS.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_vld  in  1  input sample valid; one bin per asserted cycle, gaps allowed
i_sof  in  1  start of frame; qualified by i_vld; marks bin 0
i_mag  in  WIDTH  signed magnitude from CORDIC, carries gain ~1.6468
i_phase  in  32  phase, Q2.30 radians, passed through untouched
o_vld  out  1  single-cycle pulse, peak result valid
o_bin  out  $clog2(N_BINS)  index of the peak bin
o_mag  out  WIDTH  gain-compensated peak magnitude, unsigned value
o_phase  out  32  phase of the peak bin

Behaviour:
- Reset values: o_vld=0, o_bin=0, o_mag=0, o_phase=0. Internal state also resets: bin counter=0, best_mag=0, best_bin=BIN_LO, best_phase=0, found=0.
- Bin counter: increments on each i_vld and wraps from N_BINS-1 to 0. When i_vld&&i_sof, the current sample is treated as bin 0. Any partial frame in progress is discarded and produces no output.
- Magnitude clamp: a negative i_mag is treated as 0.
- Search: a sample is in window when BIN_LO <= bin <= BIN_HI.
  - The first in-window sample of a frame loads best unconditionally.
  - Later in-window samples replace best only if mag > best_mag (strictly greater). On ties the earliest bin wins.
  - Out-of-window samples never affect best.
- End of frame: the sample at bin N_BINS-1 latches best into the compensation pipeline and clears the search state for the next frame in the same cycle. The next sample may be bin 0 of a new frame with no bubble.
- Gain compensation: o_mag = (best_mag * 39797) >> 16, with 39797 = round(0.6072529350 * 2^16). The product is 16+WIDTH bits unsigned; the result is truncated, not rounded. The multiply is registered.
- Latency: last-bin sample accepted at edge t; o_vld is high during cycle t+2 for exactly one cycle. o_bin, o_mag and o_phase are valid while o_vld is high and hold until the next result.
- Reset mid-frame: the frame is discarded and any pending result in the pipeline is dropped (o_vld stays 0).
- Frames arriving back to back produce one o_vld per frame; the pipeline never stalls and has no backpressure.

Optional Feature:
Macro PEAK_THRESH_EN.
- Defined: adds input i_thresh [WIDTH-1:0] and output o_det [1].
  - o_det is registered alongside o_mag and equals (compensated magnitude >= i_thresh).
  - i_thresh is sampled in the same cycle as the final bin.
  - o_det resets to 0.
- Undefined: neither port exists and no comparator is built.

Decomposition:
- Package dsp_post_pkg holds:
  - CORDIC_GAIN_Q16 = 16'd39797;
  - PHASE_W = 32;
  - typedef struct peak_t {bin, mag, phase}.
- One sub-module, cordic_gain_comp: a registered constant multiply plus shift, with valid passthrough. It is reusable wherever the CORDIC magnitude is consumed.

Test Plan:
- Basic peak. N_BINS=8, BIN_LO=1, BIN_HI=6. Magnitudes are 10 in every bin except bin 3 = 1000 with phase 0x12345678, sof at bin 0. Required response: one o_vld 2 cycles after bin 7, o_bin=3, o_mag=607, o_phase=0x12345678.
- Tie. Bins 2 and 5 are both 500, all others 0. Required response: o_bin=2, o_mag=303.
- Window exclusion. Bins 0 and 7 are 30000, bin 4 is 10, others 0. Required response: o_bin=4, o_mag=6. A negative i_mag in bin 5 is ignored (clamped to 0).
- Gapped input. Repeat the basic-peak scenario with i_vld high every 3rd cycle. Required response: identical outputs, with o_vld 2 cycles after the last accepted sample.
- Reset and resync.
  - rst asserted after bin 4, then a full clean frame: exactly one o_vld, for the new frame only.
  - i_sof reasserted at old bin 5: the partial frame is discarded and the new frame is counted from that sample.
- PEAK_THRESH_EN. With the basic-peak stimulus, i_thresh=607 gives o_det=1 and i_thresh=608 gives o_det=0.
